// File: rtl/game_pkg.sv
// Shared encodings for the maze/bomb game: top-level game states, per-turn phases,
// default win score and a turn hand-over helper.
package game_pkg;

  // Values match the state LED decode.
  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    PH_FREE  = 2'b00,
    PH_ARMED = 2'b01,
    PH_BLAST = 2'b10
  } phase_e;

  localparam int unsigned WIN_SCORE_DEFAULT = 10;

  function automatic game_state_e other_player(game_state_e s);
    return (s == QGAME_1) ? QGAME_2 : QGAME_1;
  endfunction

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down-counter stepped by the game tick. tc_o marks the tick that takes it from 1 to 0.
module tick_down_counter #(
  parameter int unsigned Width = 6
) (
  input  logic             board_clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o,
  output logic             tc_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = en_i && !load_i && !clear_i && (count_q == Width'(1));

endmodule

// File: rtl/game_round_ctrl.sv
// Round/turn sequencer: game state, bomb fuse and blast window, turn hand-over and scores.
// Optional turn timeout is built only when GAME_TURN_TIMEOUT_EN is defined.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned FUSE_TICKS  = 32,
  parameter int unsigned BLAST_TICKS = 2,
  parameter int unsigned TURN_TICKS  = 200,
  parameter int unsigned WIN_SCORE   = WIN_SCORE_DEFAULT
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       tick_i,
  input  logic       bomb_req_i,
  input  logic       hit_i,
  output logic [1:0] state_o,
  output logic       move_en_o,
  output logic       bomb_armed_o,
  output logic       blast_active_o,
  output logic [5:0] fuse_cnt_o,
  output logic [3:0] p1_score_o,
  output logic [3:0] p2_score_o
);

  if (FUSE_TICKS < 1 || FUSE_TICKS > 63) begin : g_bad_fuse
    $error("FUSE_TICKS out of range");
  end
  if (BLAST_TICKS < 1 || BLAST_TICKS > 7) begin : g_bad_blast
    $error("BLAST_TICKS out of range");
  end
  if (TURN_TICKS < 1 || TURN_TICKS > 255) begin : g_bad_turn
    $error("TURN_TICKS out of range");
  end
  if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_win
    $error("WIN_SCORE out of range");
  end

  localparam logic [3:0] WinScore  = 4'(WIN_SCORE);
  localparam logic [4:0] WinScore5 = 5'(WIN_SCORE);

  logic        start_meta_q, start_sync_q, start_prev_q;
  game_state_e state_q, state_d;
  phase_e      phase_q, phase_d;
  logic        move_en_q, move_en_d;
  logic        bomb_armed_q, bomb_armed_d;
  logic        blast_active_q, blast_active_d;
  logic        hit_seen_q, hit_seen_d;
  logic [3:0]  p1_q, p1_d, p2_q, p2_d;

  logic       start_rise, in_game, fuse_load, fuse_en, fuse_tc;
  logic       blast_en, blast_tc, score_hit, timeout, turn_end, win_now, game_won;
  logic [5:0] fuse_cnt;
  logic [2:0] blast_cnt;
  logic [3:0] active_q;

  assign start_rise = start_sync_q && !start_prev_q;
  assign in_game    = ((state_q == QGAME_1) || (state_q == QGAME_2)) && start_sync_q;
  assign fuse_load  = in_game && (phase_q == PH_FREE) && bomb_req_i;
  assign fuse_en    = in_game && (phase_q == PH_ARMED) && tick_i;
  // Blast counter is non-zero exactly while the window is open.
  assign blast_en   = in_game && (blast_cnt != '0) && tick_i;
  assign score_hit  = in_game && (phase_q == PH_BLAST) && hit_i && !hit_seen_q;
  assign active_q   = (state_q == QGAME_1) ? p1_q : p2_q;
  assign win_now    = (active_q == WinScore) ||
                      (score_hit && (({1'b0, active_q} + 5'd1) == WinScore5));
  assign game_won   = blast_tc && win_now;

`ifdef GAME_TURN_TIMEOUT_EN
  logic [7:0] timer_q, timer_d, timer_inc;
  assign timer_inc = timer_q + 8'd1;
  assign timeout   = in_game && (phase_q == PH_FREE) && tick_i && !bomb_req_i &&
                     (timer_inc == 8'(TURN_TICKS));

  always_comb begin
    timer_d = timer_q;
    if (!in_game || turn_end) begin
      timer_d = '0;
    end else if ((phase_q == PH_FREE) && tick_i && !bomb_req_i) begin
      timer_d = timer_inc;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign turn_end = in_game && (blast_tc || timeout);

  tick_down_counter #(
    .Width(6)
  ) u_fuse (
    .board_clk (board_clk),
    .reset     (reset),
    .load_i    (fuse_load),
    .load_val_i(6'(FUSE_TICKS)),
    .clear_i   (!in_game),
    .en_i      (fuse_en),
    .count_o   (fuse_cnt),
    .tc_o      (fuse_tc)
  );

  tick_down_counter #(
    .Width(3)
  ) u_blast (
    .board_clk (board_clk),
    .reset     (reset),
    .load_i    (fuse_tc),
    .load_val_i(3'(BLAST_TICKS)),
    .clear_i   (!in_game),
    .en_i      (blast_en),
    .count_o   (blast_cnt),
    .tc_o      (blast_tc)
  );

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      start_meta_q   <= 1'b0;
      start_sync_q   <= 1'b0;
      start_prev_q   <= 1'b0;
      state_q        <= QI;
      phase_q        <= PH_FREE;
      move_en_q      <= 1'b0;
      bomb_armed_q   <= 1'b0;
      blast_active_q <= 1'b0;
      hit_seen_q     <= 1'b0;
      p1_q           <= '0;
      p2_q           <= '0;
    end else begin
      start_meta_q   <= start_i;
      start_sync_q   <= start_meta_q;
      start_prev_q   <= start_sync_q;
      state_q        <= state_d;
      phase_q        <= phase_d;
      move_en_q      <= move_en_d;
      bomb_armed_q   <= bomb_armed_d;
      blast_active_q <= blast_active_d;
      hit_seen_q     <= hit_seen_d;
      p1_q           <= p1_d;
      p2_q           <= p2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      QI: begin
        if (start_rise) begin
          state_d = QGAME_1;
          phase_d = PH_FREE;
        end
      end
      QGAME_1, QGAME_2: begin
        if (!start_sync_q) begin
          state_d = QI;
          phase_d = PH_FREE;
        end else if (turn_end) begin
          state_d = game_won ? QDONE : other_player(state_q);
          phase_d = PH_FREE;
        end else if (fuse_load) begin
          phase_d = PH_ARMED;
        end else if (fuse_tc) begin
          phase_d = PH_BLAST;
        end
      end
      QDONE: begin
        if (!start_sync_q) begin
          state_d = QI;
        end
      end
    endcase
  end

  always_comb begin
    move_en_d      = move_en_q;
    bomb_armed_d   = bomb_armed_q;
    blast_active_d = blast_active_q;
    hit_seen_d     = hit_seen_q;
    p1_d           = p1_q;
    p2_d           = p2_q;
    unique case (state_q)
      QI: begin
        move_en_d      = 1'b0;
        bomb_armed_d   = 1'b0;
        blast_active_d = 1'b0;
        if (start_rise) begin
          move_en_d  = 1'b1;
          hit_seen_d = 1'b0;
          p1_d       = '0;
          p2_d       = '0;
        end
      end
      QGAME_1, QGAME_2: begin
        if (!start_sync_q) begin
          move_en_d      = 1'b0;
          bomb_armed_d   = 1'b0;
          blast_active_d = 1'b0;
          hit_seen_d     = 1'b0;
        end else begin
          if (score_hit) begin
            hit_seen_d = 1'b1;
            if (state_q == QGAME_1 && p1_q < WinScore) p1_d = p1_q + 4'd1;
            if (state_q == QGAME_2 && p2_q < WinScore) p2_d = p2_q + 4'd1;
          end
          if (fuse_load) bomb_armed_d = 1'b1;
          if (fuse_tc) begin
            bomb_armed_d   = 1'b0;
            blast_active_d = 1'b1;
          end
          if (turn_end) begin
            blast_active_d = 1'b0;
            hit_seen_d     = 1'b0;
            move_en_d      = !game_won;
          end
        end
      end
      QDONE: begin
        move_en_d = 1'b0;
      end
    endcase
  end

  assign state_o        = state_q;
  assign move_en_o      = move_en_q;
  assign bomb_armed_o   = bomb_armed_q;
  assign blast_active_o = blast_active_q;
  assign fuse_cnt_o     = fuse_cnt;
  assign p1_score_o     = p1_q;
  assign p2_score_o     = p2_q;

endmodule
